jtkunio_romrsp: RTL and testbench

//  Serves the video graphics ROM fetches (char, scroll, object) from one shared SDRAM read port.

---
 rtl/jtkunio_romrsp_pkg.sv | 31 +++
 rtl/jtkunio_romrsp_slot.sv | 43 ++++
 rtl/jtkunio_romrsp.sv | 203 ++++++++++++++++++++
 tb/tb_jtkunio_romrsp.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_romrsp_pkg.sv
// Shared types and widths for the graphics ROM response block.
package jtkunio_romrsp_pkg;

  localparam int unsigned AW_CHAR  = 14;
  localparam int unsigned AW_SCR   = 17;
  localparam int unsigned AW_OBJ   = 18;
  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned DW       = 32;

  typedef enum logic [1:0] {
    SLOT_CHAR = 2'd0,
    SLOT_SCR  = 2'd1,
    SLOT_OBJ  = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } state_e;

  // Round-robin successor: char -> scr -> obj -> char.
  function automatic slot_e slot_next(slot_e s);
    case (s)
      SLOT_CHAR: return SLOT_SCR;
      SLOT_SCR:  return SLOT_OBJ;
      default:   return SLOT_CHAR;
    endcase
  endfunction

endpackage

// File: rtl/jtkunio_romrsp_slot.sv
// One-word cache for a single ROM client: tag, valid, data and the hit compare.
module jtkunio_romrsp_slot
  import jtkunio_romrsp_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] wr_tag_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] data_o,
  output logic          ok_o,
  output logic          miss_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;

  // Cache line update: filled only when the fetch for this slot returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag_i;
      data_q  <= wr_data_i;
    end
  end

  // Zero-latency hit test against the live address.
  always_comb begin
    ok_o   = req_i & valid_q & (tag_q == addr_i);
    miss_o = req_i & ~ok_o;
    data_o = data_q;
  end

endmodule

// File: rtl/jtkunio_romrsp.sv
// Graphics ROM response: three cached slots sharing one SDRAM read port.
// Optional build macro JTKUNIO_ROMRSP_STATS_EN adds miss/latency statistics.
module jtkunio_romrsp
  import jtkunio_romrsp_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00_0000,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h00_4000,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h02_4000
) (
  input  logic                clk,
  input  logic                rst,
`ifdef JTKUNIO_ROMRSP_STATS_EN
  input  logic [1:0]          st_sel_i,
  output logic [7:0]          st_dout_o,
`endif
  input  logic [AW_CHAR-1:0]  char_addr_i,
  output logic [DW-1:0]       char_data_o,
  output logic                char_ok_o,
  input  logic [AW_SCR-1:0]   scr_addr_i,
  output logic [DW-1:0]       scr_data_o,
  output logic                scr_ok_o,
  input  logic                obj_cs_i,
  input  logic [AW_OBJ-1:0]   obj_addr_i,
  output logic [DW-1:0]       obj_data_o,
  output logic                obj_ok_o,
  output logic [SDRAM_AW-1:0] sdram_addr_o,
  output logic                sdram_req_o,
  input  logic                sdram_ack_i,
  input  logic                sdram_rdy_i,
  input  logic [DW-1:0]       sdram_din_i
);

  state_e              state_q, state_d;
  slot_e               ptr_q, ptr_d;
  slot_e               cur_q, cur_d;
  slot_e               c0, c1, c2, pick;
  logic [AW_OBJ-1:0]   tag_q, tag_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                req_q, req_d;
  logic                store;
  logic [2:0]          miss;
  logic [2:0]          wr;

  jtkunio_romrsp_slot #(.AW(AW_CHAR)) u_char (
    .clk      (clk),
    .rst      (rst),
    .req_i    (1'b1),
    .addr_i   (char_addr_i),
    .wr_i     (wr[SLOT_CHAR]),
    .wr_tag_i (tag_q[AW_CHAR-1:0]),
    .wr_data_i(sdram_din_i),
    .data_o   (char_data_o),
    .ok_o     (char_ok_o),
    .miss_o   (miss[SLOT_CHAR])
  );

  jtkunio_romrsp_slot #(.AW(AW_SCR)) u_scr (
    .clk      (clk),
    .rst      (rst),
    .req_i    (1'b1),
    .addr_i   (scr_addr_i),
    .wr_i     (wr[SLOT_SCR]),
    .wr_tag_i (tag_q[AW_SCR-1:0]),
    .wr_data_i(sdram_din_i),
    .data_o   (scr_data_o),
    .ok_o     (scr_ok_o),
    .miss_o   (miss[SLOT_SCR])
  );

  jtkunio_romrsp_slot #(.AW(AW_OBJ)) u_obj (
    .clk      (clk),
    .rst      (rst),
    .req_i    (obj_cs_i),
    .addr_i   (obj_addr_i),
    .wr_i     (wr[SLOT_OBJ]),
    .wr_tag_i (tag_q),
    .wr_data_i(sdram_din_i),
    .data_o   (obj_data_o),
    .ok_o     (obj_ok_o),
    .miss_o   (miss[SLOT_OBJ])
  );

  // Arbiter/FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SLOT_CHAR;
      cur_q   <= SLOT_CHAR;
      tag_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  // Round-robin pick, request launch and response handling.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    req_d   = req_q;
    store   = 1'b0;
    wr      = 3'b000;
    c0      = ptr_q;
    c1      = slot_next(c0);
    c2      = slot_next(c1);
    if (miss[c0])      pick = c0;
    else if (miss[c1]) pick = c1;
    else               pick = c2;

    unique case (state_q)
      IDLE: begin
        if (|miss) begin
          cur_d   = pick;
          req_d   = 1'b1;
          state_d = WAIT_ACK;
          // The tag is taken at launch so a later address change cannot alias the data.
          case (pick)
            SLOT_SCR: begin
              tag_d  = AW_OBJ'(scr_addr_i);
              addr_d = SCR_OFFSET + SDRAM_AW'(scr_addr_i);
            end
            SLOT_OBJ: begin
              tag_d  = obj_addr_i;
              addr_d = OBJ_OFFSET + SDRAM_AW'(obj_addr_i);
            end
            default: begin
              tag_d  = AW_OBJ'(char_addr_i);
              addr_d = CHAR_OFFSET + SDRAM_AW'(char_addr_i);
            end
          endcase
        end
      end
      WAIT_ACK: begin
        if (sdram_ack_i) begin
          req_d = 1'b0;
          if (sdram_rdy_i) store = 1'b1;
          else             state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (sdram_rdy_i) store = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (store) begin
      state_d    = IDLE;
      ptr_d      = slot_next(cur_q);
      wr[cur_q]  = 1'b1;
    end
  end

  assign sdram_addr_o = addr_q;
  assign sdram_req_o  = req_q;

`ifdef JTKUNIO_ROMRSP_STATS_EN
  logic [15:0] miss_cnt_q [3];
  logic [15:0] lat_cnt_q;
  logic [15:0] lat_last_q;
  logic [7:0]  st_dout_q;
  logic        launch;

  assign launch = (state_q == IDLE) && (state_d == WAIT_ACK);

  // Saturating miss counters, fetch latency capture and registered readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) miss_cnt_q[i] <= '0;
      lat_cnt_q  <= '0;
      lat_last_q <= '0;
      st_dout_q  <= '0;
    end else begin
      if (launch && miss_cnt_q[cur_d] != 16'hFFFF) begin
        miss_cnt_q[cur_d] <= miss_cnt_q[cur_d] + 16'd1;
      end
      if (launch) begin
        lat_cnt_q <= 16'd1;
      end else if (state_q != IDLE && lat_cnt_q != 16'hFFFF) begin
        lat_cnt_q <= lat_cnt_q + 16'd1;
      end
      if (store) lat_last_q <= lat_cnt_q;
      case (st_sel_i)
        2'd0:    st_dout_q <= miss_cnt_q[0][15:8];
        2'd1:    st_dout_q <= miss_cnt_q[1][15:8];
        2'd2:    st_dout_q <= miss_cnt_q[2][15:8];
        default: st_dout_q <= lat_last_q[15:8];
      endcase
    end
  end

  assign st_dout_o = st_dout_q;
`endif

endmodule

// File: tb/tb_jtkunio_romrsp.sv
// Self-checking bench for jtkunio_romrsp: the bench acts as the SDRAM and keeps
// an abstract model of three one-word caches plus a round-robin pointer.
module tb_jtkunio_romrsp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] char_addr = '0;
  logic [31:0] char_data;
  logic        char_ok;
  logic [16:0] scr_addr = '0;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [17:0] obj_addr = '0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_rdy = 1'b0;
  logic [31:0] sdram_din = '0;
`ifdef JTKUNIO_ROMRSP_STATS_EN
  logic [1:0]  st_sel = 2'd0;
  logic [7:0]  st_dout;
`endif

  always #5 clk = ~clk;

  jtkunio_romrsp u_dut (
    .clk         (clk),
    .rst         (rst),
`ifdef JTKUNIO_ROMRSP_STATS_EN
    .st_sel_i    (st_sel),
    .st_dout_o   (st_dout),
`endif
    .char_addr_i (char_addr),
    .char_data_o (char_data),
    .char_ok_o   (char_ok),
    .scr_addr_i  (scr_addr),
    .scr_data_o  (scr_data),
    .scr_ok_o    (scr_ok),
    .obj_cs_i    (obj_cs),
    .obj_addr_i  (obj_addr),
    .obj_data_o  (obj_data),
    .obj_ok_o    (obj_ok),
    .sdram_addr_o(sdram_addr),
    .sdram_req_o (sdram_req),
    .sdram_ack_i (sdram_ack),
    .sdram_rdy_i (sdram_rdy),
    .sdram_din_i (sdram_din)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Abstract cache model.
  bit          m_v [3];
  int unsigned m_tag [3];
  logic [31:0] m_data [3];
  int          m_ptr;

  // SDRAM responder state.
  bit          busy, acked, rdy_now;
  int          cnt, cur;
  int unsigned cur_tag, cur_addr;
  logic [31:0] din_sent;
  int          ack_max = 0, rdy_max = 0;
  bit          both_en = 0, spur_en = 0, fixed_din_en = 0, force_rdy = 0;
  logic [31:0] fixed_din = '0;
  int          launch_slot [$];
  int unsigned launch_addr [$];

  function automatic int unsigned off(int s);
    case (s)
      0:       return 32'h0;
      1:       return 32'h4000;
      default: return 32'h24000;
    endcase
  endfunction

  function automatic int unsigned cur_in(int s);
    case (s)
      0:       return 32'(char_addr);
      1:       return 32'(scr_addr);
      default: return 32'(obj_addr);
    endcase
  endfunction

  function automatic bit m_req(int s);
    return (s != 2) || obj_cs;
  endfunction

  function automatic bit m_hit(int s);
    return m_req(s) && m_v[s] && (m_tag[s] == cur_in(s));
  endfunction

  function automatic bit all_hit();
    for (int s = 0; s < 3; s++) if (m_req(s) && !m_hit(s)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic dut_ok(int s);
    case (s)
      0:       return char_ok;
      1:       return scr_ok;
      default: return obj_ok;
    endcase
  endfunction

  function automatic logic [31:0] dut_data(int s);
    case (s)
      0:       return char_data;
      1:       return scr_data;
      default: return obj_data;
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 1'b0; m_tag[s] = 0; m_data[s] = '0;
    end
    m_ptr = 0; busy = 0; acked = 0; rdy_now = 0; cnt = 0; force_rdy = 0;
  endtask

  task automatic do_reset();
    sdram_ack = 1'b0; sdram_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: respond as SDRAM, predict the next launch, then compare at negedge.
  task automatic run_cycle();
    bit          pred;
    int          ps;
    int unsigned paddr, ptag;
    pred = 0; ps = 0; paddr = 0; ptag = 0;
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    sdram_din = fixed_din_en ? fixed_din : $urandom;
    if (busy && !acked) begin
      if (cnt == 0) begin
        sdram_ack = 1'b1; acked = 1;
        cnt = (rdy_max == 0) ? 0 : int'($urandom_range(rdy_max, 0));
        if (both_en && $urandom_range(1, 0) == 1) begin
          sdram_rdy = 1'b1; rdy_now = 1; din_sent = sdram_din;
        end
      end else cnt--;
    end else if (busy && acked) begin
      if (cnt == 0) begin
        sdram_rdy = 1'b1; rdy_now = 1; din_sent = sdram_din;
      end else cnt--;
    end else if (!busy && (force_rdy || (spur_en && $urandom_range(3, 0) == 0))) begin
      sdram_rdy = 1'b1;
    end
    force_rdy = 0;
    if (!busy) begin
      for (int i = 0; i < 3; i++) begin
        int s;
        s = (m_ptr + i) % 3;
        if (!pred && m_req(s) && !m_hit(s)) begin pred = 1; ps = s; end
      end
    end
    if (pred) begin
      ptag  = cur_in(ps);
      paddr = (off(ps) + ptag) & 32'h3F_FFFF;
    end
    @(negedge clk);
    if (rdy_now) begin
      m_v[cur] = 1'b1; m_tag[cur] = cur_tag; m_data[cur] = din_sent;
      m_ptr = (cur + 1) % 3; busy = 0; rdy_now = 0;
    end
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (dut_ok(s) !== m_hit(s) || dut_data(s) !== m_data[s]) begin
        n_errors++;
        $display("FAIL slot%0d_ok_data t=%0t: got ok=%b data=%h, expected ok=%b data=%h",
                 s, $time, dut_ok(s), dut_data(s), m_hit(s), m_data[s]);
      end
    end
    n_checks++;
    if (pred) begin
      if (sdram_req !== 1'b1 || sdram_addr !== paddr[21:0]) begin
        n_errors++;
        $display("FAIL launch t=%0t: got req=%b addr=%h, expected req=1 addr=%h (slot%0d)",
                 $time, sdram_req, sdram_addr, paddr[21:0], ps);
      end
      busy = 1; acked = 0; cur = ps; cur_tag = ptag; cur_addr = paddr;
      cnt = (ack_max == 0) ? 0 : int'($urandom_range(ack_max, 0));
      launch_slot.push_back(ps);
      launch_addr.push_back(paddr);
    end else if (busy && !acked) begin
      if (sdram_req !== 1'b1 || sdram_addr !== cur_addr[21:0]) begin
        n_errors++;
        $display("FAIL req_hold t=%0t: got req=%b addr=%h, expected req=1 addr=%h",
                 $time, sdram_req, sdram_addr, cur_addr[21:0]);
      end
    end else if (sdram_req !== 1'b0) begin
      n_errors++;
      $display("FAIL req_idle t=%0t: got req=%b, expected 0", $time, sdram_req);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 300 && !(!busy && all_hit())) begin
      run_cycle();
      n++;
    end
    n_checks++;
    if (n >= 300) begin
      n_errors++;
      $display("FAIL wait_idle t=%0t: got timeout after %0d cycles, expected idle", $time, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
      n_errors++;
      $display("FAIL reset_sdram: got req=%b addr=%h, expected 0/0", sdram_req, sdram_addr);
    end
    n_checks++;
    if ({char_ok, scr_ok, obj_ok} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ok: got %b, expected 000", {char_ok, scr_ok, obj_ok});
    end
    n_checks++;
    if (char_data !== 32'h0 || scr_data !== 32'h0 || obj_data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h %h %h, expected zeros", char_data, scr_data, obj_data);
    end
    do_reset();
  endtask

  task automatic test_char_miss();
    char_addr = 14'h0010; scr_addr = '0; obj_cs = 1'b0; obj_addr = '0;
    ack_max = 0; rdy_max = 0; both_en = 0; spur_en = 0;
    fixed_din_en = 1; fixed_din = 32'hDEAD_BEEF;
    do_reset();
    run_cycle();
    n_checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h00_0010) begin
      n_errors++;
      $display("FAIL char_launch: got req=%b addr=%h, expected 1/000010", sdram_req, sdram_addr);
    end
    run_cycle();
    run_cycle();
    n_checks++;
    if (char_ok !== 1'b1 || char_data !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL char_fill: got ok=%b data=%h, expected 1/deadbeef", char_ok, char_data);
    end
    fixed_din_en = 0;
    wait_idle();
  endtask

  task automatic test_all_miss();
    logic [13:0] ca;
    logic [16:0] sa;
    logic [17:0] oa;
    int n;
    ca = 14'($urandom); sa = 17'($urandom); oa = 18'($urandom);
    char_addr = ca; scr_addr = sa; obj_addr = oa; obj_cs = 1'b1;
    ack_max = 2; rdy_max = 3;
    do_reset();
    launch_slot.delete(); launch_addr.delete();
    n = 0;
    while (n < 100 && launch_slot.size() < 3) begin run_cycle(); n++; end
    wait_idle();
    n_checks++;
    if (launch_slot.size() != 3) begin
      n_errors++;
      $display("FAIL all_miss_count: got %0d launches, expected 3", launch_slot.size());
    end else begin
      n_checks++;
      if (launch_slot[0] != 0 || launch_slot[1] != 1 || launch_slot[2] != 2) begin
        n_errors++;
        $display("FAIL all_miss_order: got %0d,%0d,%0d, expected 0,1,2",
                 launch_slot[0], launch_slot[1], launch_slot[2]);
      end
      n_checks++;
      if (launch_addr[0] != 32'(ca) || launch_addr[1] != 32'h4000 + 32'(sa) ||
          launch_addr[2] != 32'h24000 + 32'(oa)) begin
        n_errors++;
        $display("FAIL all_miss_addr: got %h,%h,%h, expected %h,%h,%h", launch_addr[0],
                 launch_addr[1], launch_addr[2], ca, 32'h4000 + 32'(sa), 32'h24000 + 32'(oa));
      end
    end
    n_checks++;
    if ({char_ok, scr_ok, obj_ok} !== 3'b111) begin
      n_errors++;
      $display("FAIL all_miss_ok: got %b, expected 111", {char_ok, scr_ok, obj_ok});
    end
  endtask

  task automatic test_addr_change();
    logic [16:0] a, b;
    int n, scr_cnt;
    int unsigned last_scr;
    a = scr_addr ^ 17'h0_0101;
    b = scr_addr ^ 17'h1_2020;
    both_en = 0; ack_max = 1; rdy_max = 3;
    launch_slot.delete(); launch_addr.delete();
    scr_addr = a;
    n = 0;
    while (n < 50 && !(busy && acked && cur == 1)) begin run_cycle(); n++; end
    scr_addr = b;
    wait_idle();
    scr_cnt = 0; last_scr = 0;
    foreach (launch_slot[i]) if (launch_slot[i] == 1) begin
      scr_cnt++; last_scr = launch_addr[i];
    end
    n_checks++;
    if (scr_cnt != 2 || last_scr != 32'h4000 + 32'(b)) begin
      n_errors++;
      $display("FAIL addr_change: got %0d scr launches last=%h, expected 2 last=%h",
               scr_cnt, last_scr, 32'h4000 + 32'(b));
    end
    n_checks++;
    if (scr_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL addr_change_ok: got %b, expected 1", scr_ok);
    end
  endtask

  task automatic test_obj_cs();
    int n0;
    obj_cs = 1'b1;
    wait_idle();
    n0 = launch_slot.size();
    obj_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      n_checks++;
      if (obj_ok !== 1'b0) begin
        n_errors++;
        $display("FAIL obj_cs_low: got obj_ok=%b, expected 0", obj_ok);
      end
    end
    obj_cs = 1'b1;
    #1;
    n_checks++;
    if (obj_ok !== 1'b1 || obj_data !== m_data[2]) begin
      n_errors++;
      $display("FAIL obj_cs_back: got ok=%b data=%h, expected 1/%h", obj_ok, obj_data, m_data[2]);
    end
    for (int i = 0; i < 3; i++) run_cycle();
    n_checks++;
    if (launch_slot.size() != n0) begin
      n_errors++;
      $display("FAIL obj_cs_noreq: got %0d launches, expected %0d", launch_slot.size(), n0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    ack_max = 0; rdy_max = 6; both_en = 0; spur_en = 0;
    char_addr = char_addr ^ 14'h1234;
    n = 0;
    while (n < 50 && !(busy && acked && cur == 0 && cnt > 0)) begin run_cycle(); n++; end
    n_checks++;
    if (n >= 50) begin
      n_errors++;
      $display("FAIL reset_mid_setup: got timeout, expected char fetch in flight");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_mid: got ok=%b req=%b, expected 000/0",
               {char_ok, scr_ok, obj_ok}, sdram_req);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    force_rdy = 1;
    run_cycle();
    n_checks++;
    if (char_ok !== 1'b0 || char_data !== 32'h0) begin
      n_errors++;
      $display("FAIL late_rdy: got ok=%b data=%h, expected 0/0", char_ok, char_data);
    end
    wait_idle();
    n_checks++;
    if (char_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_refetch: got char_ok=%b, expected 1", char_ok);
    end
  endtask

  task automatic test_random();
    logic [13:0] cpool [4] = '{14'h0010, 14'h0011, 14'h3FFF, 14'h2000};
    logic [16:0] spool [4] = '{17'h0_0000, 17'h1_FFFF, 17'h0_4000, 17'h0_0123};
    logic [17:0] opool [4] = '{18'h0_0000, 18'h3_FFFF, 18'h2_0000, 18'h0_0777};
    ack_max = 3; rdy_max = 4; both_en = 1; spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(15, 0))
        0:       char_addr = cpool[$urandom_range(3, 0)];
        1:       scr_addr  = spool[$urandom_range(3, 0)];
        2:       obj_addr  = opool[$urandom_range(3, 0)];
        3:       obj_cs    = ~obj_cs;
        default: ;
      endcase
      run_cycle();
    end
    spur_en = 0;
    wait_idle();
  endtask

`ifdef JTKUNIO_ROMRSP_STATS_EN
  task automatic test_stats();
    ack_max = 0; rdy_max = 0; both_en = 0; spur_en = 0;
    obj_cs = 1'b0; char_addr = '0; st_sel = 2'd0;
    do_reset();
    wait_idle();
    for (int i = 1; i < 'h1FF; i++) begin
      char_addr = 14'(i);
      wait_idle();
    end
    run_cycle();
    run_cycle();
    n_checks++;
    if (st_dout !== 8'h01) begin
      n_errors++;
      $display("FAIL stats_char: got st_dout=%h, expected 01", st_dout);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1;
    test_reset();
    test_char_miss();
    test_all_miss();
    test_addr_change();
    test_obj_cs();
    test_reset_mid();
    test_random();
`ifdef JTKUNIO_ROMRSP_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
